// File: rtl/mac_sequencer.sv
// Layer controller: drains paired activation/weight buffers into a shared MAC unit and writes one result per neuron.
// Optional `MAC_SEQUENCER_RELU_EN applies ReLU to the value written to the output buffer.
module mac_sequencer #(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 8,
    parameter int MAC_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           in_buf_empty,
    input  logic [31:0]                    in_buf_read_data,
    output logic                           in_buf_read_enable,
    input  logic                           wt_buf_empty,
    input  logic [31:0]                    wt_buf_read_data,
    output logic                           wt_buf_read_enable,
    output logic                           mac_valid,
    output logic                           mac_first,
    output logic                           mac_last,
    output logic [31:0]                    mac_a,
    output logic [31:0]                    mac_b,
    input  logic [31:0]                    mac_result,
    input  logic                           out_buf_full,
    output logic                           out_buf_write_enable,
    output logic [31:0]                    out_buf_write_data,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_NEURONS):0]   neuron_idx
);

    localparam int BW = $clog2(NUM_INPUTS) + 1;
    localparam int DW = $clog2(MAC_LATENCY) + 1;
    localparam int NW = $clog2(NUM_NEURONS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [NW-1:0]   neuron_idx_q, neuron_idx_d;

    logic            fire;
    logic            last_beat;
    logic            last_neuron;
    logic            wr_fire;
    logic [31:0]     result_data;

    // Both buffers pop together; a lone non-empty buffer never advances the dot product.
    assign fire        = (state_q == S_FETCH) && !in_buf_empty && !wt_buf_empty;
    assign last_beat   = (beat_cnt_q == BW'(NUM_INPUTS - 1));
    assign last_neuron = (neuron_idx_q == NW'(NUM_NEURONS - 1));
    assign wr_fire     = (state_q == S_WRITE) && !out_buf_full;

`ifdef MAC_SEQUENCER_RELU_EN
    assign result_data = mac_result[31] ? 32'd0 : mac_result;
`else
    assign result_data = mac_result;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            neuron_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            neuron_idx_q <= neuron_idx_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        neuron_idx_d = neuron_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_FETCH;
                    beat_cnt_d   = '0;
                    neuron_idx_d = '0;
                end
            end
            S_FETCH: begin
                if (fire) begin
                    if (last_beat) begin
                        beat_cnt_d  = '0;
                        drain_cnt_d = '0;
                        state_d     = S_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DW'(MAC_LATENCY - 1)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_fire) begin
                    if (last_neuron) begin
                        state_d = S_DONE;
                    end else begin
                        neuron_idx_d = neuron_idx_q + 1'b1;
                        state_d      = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_buf_read_enable   = 1'b0;
        wt_buf_read_enable   = 1'b0;
        mac_valid            = 1'b0;
        mac_first            = 1'b0;
        mac_last             = 1'b0;
        mac_a                = '0;
        mac_b                = '0;
        out_buf_write_enable = 1'b0;
        out_buf_write_data   = '0;
        done                 = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                in_buf_read_enable = fire;
                wt_buf_read_enable = fire;
                mac_valid          = fire;
                mac_first          = fire && (beat_cnt_q == '0);
                mac_last           = fire && last_beat;
                if (fire) begin
                    mac_a = in_buf_read_data;
                    mac_b = wt_buf_read_data;
                end
            end
            S_WRITE: begin
                out_buf_write_enable = !out_buf_full;
                out_buf_write_data   = result_data;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign neuron_idx = neuron_idx_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: queue-based buffers, a MAC stub and dot products computed directly from pushed data.
// Honours MAC_SEQUENCER_RELU_EN when computing expected written values.
module tb_mac_sequencer;

    localparam int NI = 4;
    localparam int NN = 2;
    localparam int ML = 2;
    localparam int NW = $clog2(NN) + 1;
    localparam int PER_NEURON = NI + ML + 1;
    localparam int LAYER_CYCLES = NN * PER_NEURON + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          in_buf_empty;
    logic [31:0]   in_buf_read_data;
    logic          in_buf_read_enable;
    logic          wt_buf_empty;
    logic [31:0]   wt_buf_read_data;
    logic          wt_buf_read_enable;
    logic          mac_valid, mac_first, mac_last;
    logic [31:0]   mac_a, mac_b;
    logic [31:0]   mac_result;
    logic          out_buf_full = 1'b0;
    logic          out_buf_write_enable;
    logic [31:0]   out_buf_write_data;
    logic          busy, done;
    logic [NW-1:0] neuron_idx;

    always #5 clk = ~clk;

    mac_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .MAC_LATENCY(ML)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_buf_empty(in_buf_empty), .in_buf_read_data(in_buf_read_data),
        .in_buf_read_enable(in_buf_read_enable),
        .wt_buf_empty(wt_buf_empty), .wt_buf_read_data(wt_buf_read_data),
        .wt_buf_read_enable(wt_buf_read_enable),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
        .mac_a(mac_a), .mac_b(mac_b), .mac_result(mac_result),
        .out_buf_full(out_buf_full), .out_buf_write_enable(out_buf_write_enable),
        .out_buf_write_data(out_buf_write_data),
        .busy(busy), .done(done), .neuron_idx(neuron_idx)
    );

    logic [31:0] in_q[$], wt_q[$];     // live buffer contents
    logic [31:0] exp_a[$], exp_w[$];   // everything pushed, in order
    logic [31:0] wr_log[$];
    logic [31:0] acc = '0;
    bit          mac_ovr = 1'b0;
    logic [31:0] mac_ovr_val = '0;
    int          checks = 0;
    int          failures = 0;
    int          p, n, fires;
    bit          found;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        in_buf_empty     = (in_q.size() == 0);
        in_buf_read_data = in_buf_empty ? 32'd0 : in_q[0];
        wt_buf_empty     = (wt_q.size() == 0);
        wt_buf_read_data = wt_buf_empty ? 32'd0 : wt_q[0];
        mac_result       = mac_ovr ? mac_ovr_val : acc;
    endtask

    task automatic push_in(input logic [31:0] v);
        in_q.push_back(v);
        exp_a.push_back(v);
    endtask

    task automatic push_wt(input logic [31:0] v);
        wt_q.push_back(v);
        exp_w.push_back(v);
    endtask

    function automatic logic [31:0] rnd();
        return 32'($urandom_range(200)) - 32'd100;
    endfunction

    function automatic logic [31:0] dot(input int base);
        logic [31:0] s = '0;
        for (int k = 0; k < NI; k++) s += exp_a[base + k] * exp_w[base + k];
        return s;
    endfunction

    function automatic logic [31:0] exp_out(input logic [31:0] r);
`ifdef MAC_SEQUENCER_RELU_EN
        return $signed(r) < 0 ? 32'd0 : r;
`else
        return r;
`endif
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
    endtask

    task automatic wait_write(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (out_buf_write_enable) hit = 1'b1;
        end
        check("write_seen", hit, 1'b1);
    endtask

    // Buffer pops and the MAC stub react to pre-edge enables, updating just after the edge.
    always @(posedge clk) begin
        bit pi, pw, v, f;
        logic [31:0] a, b;
        pi = in_buf_read_enable;
        pw = wt_buf_read_enable;
        v  = mac_valid;
        f  = mac_first;
        a  = mac_a;
        b  = mac_b;
        if (out_buf_write_enable) wr_log.push_back(out_buf_write_data);
        #1;
        if (pi && in_q.size() > 0) void'(in_q.pop_front());
        if (pw && wt_q.size() > 0) void'(wt_q.pop_front());
        if (v) acc = (f ? 32'd0 : acc) + a * b;
        refresh();
    end

    initial begin
        refresh();
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_rd", in_buf_read_enable, 1'b0);
        check("rst_wr_en", out_buf_write_enable, 1'b0);
        check("rst_nidx", neuron_idx, '0);
        reset_n = 1'b1;

        // Full layer with preloaded buffers, plus start pulses while busy and in DONE
        for (int i = 0; i < NI * NN; i++) begin
            push_in(rnd());
            push_wt(rnd());
        end
        refresh();
        pulse_start();
        for (int c = 1; c <= LAYER_CYCLES + 2; c++) begin
            if (c > 1) @(negedge clk);
            p = (c - 1) % PER_NEURON;
            n = (c - 1) / PER_NEURON;
            if (c < LAYER_CYCLES) begin
                check("l1_busy", busy, 1'b1);
                check("l1_nidx", neuron_idx, NW'(n));
                check("l1_valid", mac_valid, p < NI);
                check("l1_in_rd", in_buf_read_enable, p < NI);
                check("l1_wr_en", out_buf_write_enable, p == PER_NEURON - 1);
                if (p < NI) begin
                    check("l1_mac_a", mac_a, exp_a[n * NI + p]);
                    check("l1_mac_b", mac_b, exp_w[n * NI + p]);
                    check("l1_first", mac_first, p == 0);
                    check("l1_last", mac_last, p == NI - 1);
                end
                if (p == PER_NEURON - 1) check("l1_wr_data", out_buf_write_data, exp_out(dot(n * NI)));
            end else begin
                check("l1_busy_end", busy, c == LAYER_CYCLES);
                check("l1_nidx_hold", neuron_idx, NW'(NN - 1));
            end
            check("l1_done", done, c == LAYER_CYCLES);
            if (c == 3 || c == LAYER_CYCLES) start = 1'b1;
            else start = 1'b0;
        end

        // Stall on unequal buffers, then output-full backpressure in WRITE
        exp_a.delete();
        exp_w.delete();
        for (int i = 0; i < NI - 1; i++) push_in(rnd());
        for (int i = 0; i < NI; i++) push_wt(rnd());
        out_buf_full = 1'b1;
        refresh();
        pulse_start();
        fires = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            if (mac_valid && in_buf_read_enable && wt_buf_read_enable) fires++;
            check("st_wt_rd", wt_buf_read_enable, c <= NI - 1);
        end
        check("st_fires", fires, NI - 1);
        check("st_busy", busy, 1'b1);
        push_in(rnd());
        refresh();
        #1;
        check("st_fire_valid", mac_valid, 1'b1);
        check("st_fire_last", mac_last, 1'b1);
        check("st_fire_first", mac_first, 1'b0);
        check("st_fire_a", mac_a, exp_a[NI - 1]);
        repeat (ML) begin
            @(negedge clk);
            check("st_drain_valid", mac_valid, 1'b0);
            check("st_drain_wr", out_buf_write_enable, 1'b0);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("full_wr_en", out_buf_write_enable, 1'b0);
            check("full_busy", busy, 1'b1);
            check("full_nidx", neuron_idx, '0);
        end
        out_buf_full = 1'b0;
        #1;
        check("full_rel_wr_en", out_buf_write_enable, 1'b1);
        check("full_rel_data", out_buf_write_data, exp_out(dot(0)));
        @(negedge clk);
        check("next_nidx", neuron_idx, NW'(1));
        check("next_wr_en", out_buf_write_enable, 1'b0);
        wr_log.delete();
        for (int i = 0; i < NI; i++) begin
            push_in(rnd());
            push_wt(rnd());
        end
        refresh();
        wait_done(4 * LAYER_CYCLES);
        check("st_wr_count", wr_log.size(), 1);
        if (wr_log.size() > 0) check("st_wr_n1", wr_log[0], exp_out(dot(NI)));
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_nidx_hold", neuron_idx, NW'(NN - 1));

        // Reset in the middle of FETCH, then restart from the surviving buffer contents
        exp_a.delete();
        exp_w.delete();
        for (int i = 0; i < NI * NN; i++) begin
            push_in(rnd());
            push_wt(rnd());
        end
        refresh();
        pulse_start();
        repeat (2) @(negedge clk);
        check("pre_rst_a", mac_a, exp_a[2]);
        reset_n = 1'b0;
        #1;
        check("mid_rst_in_rd", in_buf_read_enable, 1'b0);
        check("mid_rst_wt_rd", wt_buf_read_enable, 1'b0);
        check("mid_rst_valid", mac_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_nidx", neuron_idx, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_cnt", in_q.size(), NI * NN - 2);
        for (int i = 0; i < 2; i++) begin
            push_in(rnd());
            push_wt(rnd());
        end
        refresh();
        wr_log.delete();
        pulse_start();
        check("rs_first", mac_first, 1'b1);
        check("rs_a", mac_a, exp_a[2]);
        check("rs_nidx", neuron_idx, '0);
        wait_done(4 * LAYER_CYCLES);
        check("rs_wr_count", wr_log.size(), NN);
        if (wr_log.size() == NN) begin
            check("rs_wr0", wr_log[0], exp_out(dot(2)));
            check("rs_wr1", wr_log[1], exp_out(dot(2 + NI)));
        end

        // Result shaping on negative and positive MAC results
        for (int i = 0; i < NI * NN; i++) begin
            push_in(rnd());
            push_wt(rnd());
        end
        mac_ovr     = 1'b1;
        mac_ovr_val = 32'hFFFF_FFF6;
        refresh();
        pulse_start();
        wait_write(4 * LAYER_CYCLES, found);
        if (found) check("relu_neg", out_buf_write_data, exp_out(32'hFFFF_FFF6));
        mac_ovr_val = 32'd7;
        refresh();
        @(negedge clk);
        wait_write(4 * LAYER_CYCLES, found);
        if (found) check("relu_pos", out_buf_write_data, 32'd7);
        wait_done(4 * LAYER_CYCLES);
        mac_ovr = 1'b0;
        refresh();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
